// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner with debounce, one KEY_Value/Value_en strobe per press.
// Press latency <= 2+SCAN_DIV+DEBOUNCE_CNT cycles (+3*SCAN_DIV worst column); no backpressure. KEYPAD_REPEAT_EN adds hold auto-repeat.
module keypad_scan #(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 20000
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DLY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000
`endif
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] KEY_Value,
    output logic       Value_en,
    output logic       key_held
);

    localparam int DW_W = $clog2(SCAN_DIV);
    localparam int DB_W = $clog2(DEBOUNCE_CNT);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DB_W-1:0] DB_FIRST   = DB_W'(1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

    logic [3:0]      r_sync1;
    logic [3:0]      r_rs;
    state_t          r_state;
    logic [1:0]      r_col;
    logic [1:0]      r_row;
    logic [3:0]      r_pat;
    logic [DW_W-1:0] r_dwell;
    logic [DB_W-1:0] r_cnt;
    logic [3:0]      r_col_out;
    logic [3:0]      r_key;
    logic            r_vld;
    logic            r_held;

    logic            w_one_low;
    logic [1:0]      w_row_idx;
    logic [1:0]      w_col_next;

`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_PERIOD) ? REPEAT_DLY : REPEAT_PERIOD;
    localparam int HD_W     = $clog2(HOLD_MAX);
    localparam logic [HD_W-1:0] HOLD_FIRST = HD_W'(REPEAT_DLY - 1);
    localparam logic [HD_W-1:0] HOLD_NEXT  = HD_W'(REPEAT_PERIOD - 1);

    logic [HD_W-1:0] r_hold;
    logic            r_rep;
    logic            w_hold_hit;

    // First repeat waits REPEAT_DLY, later ones REPEAT_PERIOD.
    always_comb begin
        w_hold_hit = (r_hold == (r_rep ? HOLD_NEXT : HOLD_FIRST));
    end
`endif

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd10;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd11;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd12;
            4'hC: code = 4'd14;
            4'hD: code = 4'd0;
            4'hE: code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    always_comb begin
        w_one_low  = 1'b1;
        w_row_idx  = 2'd0;
        w_col_next = r_col + 2'd1;
        case (r_rs)
            4'b1110: w_row_idx = 2'd0;
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 4'hF;
            r_rs    <= 4'hF;
        end else begin
            r_sync1 <= row_in;
            r_rs    <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_SCAN;
            r_col     <= 2'd0;
            r_row     <= 2'd0;
            r_pat     <= 4'hF;
            r_dwell   <= '0;
            r_cnt     <= '0;
            r_col_out <= 4'b1110;
            r_key     <= 4'd0;
            r_vld     <= 1'b0;
            r_held    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_hold    <= '0;
            r_rep     <= 1'b0;
`endif
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                S_SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        if (w_one_low) begin
                            r_row   <= w_row_idx;
                            r_pat   <= r_rs;
                            r_cnt   <= DB_FIRST;
                            r_state <= S_DEBOUNCE;
                        end else begin
                            r_col     <= w_col_next;
                            r_col_out <= ~(4'b0001 << w_col_next);
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                S_DEBOUNCE: begin
                    if (r_rs == r_pat) begin
                        if (r_cnt == DB_LAST) begin
                            r_state <= S_PRESSED;
                            r_vld   <= 1'b1;
                            r_key   <= key_code(r_row, r_col);
                            r_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            r_hold  <= '0;
                            r_rep   <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        // Column stays frozen so the same key is retried first.
                        r_state <= S_SCAN;
                        r_dwell <= '0;
                    end
                end
                S_PRESSED: begin
                    if (r_rs[r_row]) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= DB_FIRST;
`ifdef KEYPAD_REPEAT_EN
                        r_hold  <= '0;
                        r_rep   <= 1'b0;
                    end else if (w_hold_hit) begin
                        r_vld  <= 1'b1;
                        r_hold <= '0;
                        r_rep  <= 1'b1;
                    end else begin
                        r_hold <= r_hold + 1'b1;
`endif
                    end
                end
                S_RELEASE: begin
                    if (r_rs[r_row]) begin
                        if (r_cnt == DB_LAST) begin
                            r_state   <= S_SCAN;
                            r_held    <= 1'b0;
                            r_dwell   <= '0;
                            r_col     <= w_col_next;
                            r_col_out <= ~(4'b0001 << w_col_next);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_state <= S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        r_hold  <= '0;
                        r_rep   <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_SCAN;
            endcase
        end
    end

    assign col_out   = r_col_out;
    assign KEY_Value = r_key;
    assign Value_en  = r_vld;
    assign key_held  = r_held;

endmodule
